// File: rtl/trap_ctrl_if.sv
// Decoder/fetch-side signal bundle of the user-level trap controller.
interface trap_ctrl_if;
    logic        instr_valid;
    logic [31:0] PC;
    logic        ecall;
    logic        uret;
    logic        CSRRSI;
    logic        CSRRCI;
    logic [11:0] csr_addr;
    logic [4:0]  zimm;
    logic [2:0]  IRQ;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        squash;
    logic [31:0] csr_rdata;
    logic        UIE;
    logic        UPIE;
    logic [31:0] UEPC;
    logic [31:0] UCAUSE;
    logic [2:0]  pending;

    modport master (
        output instr_valid, PC, ecall, uret, CSRRSI, CSRRCI, csr_addr, zimm, IRQ,
        input  pc_redirect, pc_target, squash, csr_rdata, UIE, UPIE, UEPC, UCAUSE, pending
    );

    modport slave (
        input  instr_valid, PC, ecall, uret, CSRRSI, CSRRCI, csr_addr, zimm, IRQ,
        output pc_redirect, pc_target, squash, csr_rdata, UIE, UPIE, UEPC, UCAUSE, pending
    );
endinterface

// File: rtl/trap_ctrl.sv
// User-level trap controller: ustatus/uepc/ucause, ecall/uret/CSR ops, PC redirect.
// TRAP_CTRL_IRQ_EN builds the external interrupt latch and interrupt entry path.
module trap_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RST_N,
    trap_ctrl_if.slave  bus
);

    logic        uie_r;
    logic        upie_r;
    logic [31:0] uepc_r;
    logic [31:0] ucause_r;
    logic [2:0]  pending_s;
    logic        int_take_s;
    logic [1:0]  irq_id_s;
    logic        csr_hit_s;
    logic        unused_ok_s;

    assign csr_hit_s = (bus.csr_addr == 12'h000);

`ifdef TRAP_CTRL_IRQ_EN
    logic [2:0] irq_d_r;
    logic [2:0] pending_r;
    logic [2:0] irq_rise_s;
    logic [2:0] clr_s;
    logic [2:0] pending_nxt_s;

    function automatic logic [1:0] irq_select(input logic [2:0] req);
        logic [1:0] id;
        if (req[2]) begin
            id = 2'd2;
        end else if (req[1]) begin
            id = 2'd1;
        end else begin
            id = 2'd0;
        end
        return id;
    endfunction

    assign irq_rise_s = bus.IRQ & ~irq_d_r;
    assign int_take_s = bus.instr_valid & uie_r & (|pending_r);
    assign irq_id_s   = irq_select(pending_r);
    assign pending_s  = pending_r;

    // Clear mask for the source being taken; a same-cycle rising edge re-sets it.
    always_comb begin
        clr_s = 3'b000;
        if (int_take_s) begin
            clr_s[irq_id_s] = 1'b1;
        end else begin
            clr_s = 3'b000;
        end
        pending_nxt_s = (pending_r & ~clr_s) | irq_rise_s;
    end

    // IRQ edge detector and pending request latch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_d_r   <= 3'b000;
            pending_r <= 3'b000;
        end else begin
            irq_d_r   <= bus.IRQ;
            pending_r <= pending_nxt_s;
        end
    end

    assign unused_ok_s = ^bus.zimm[3:1];
`else
    assign int_take_s  = 1'b0;
    assign irq_id_s    = 2'b00;
    assign pending_s   = 3'b000;
    assign unused_ok_s = ^{bus.zimm[3:1], bus.IRQ};
`endif

    // Trap state: interrupt entry outranks ecall, uret and the CSR ops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            uie_r    <= 1'b0;
            upie_r   <= 1'b0;
            uepc_r   <= 32'h0000_0000;
            ucause_r <= 32'h0000_0000;
        end else if (int_take_s) begin
            uepc_r   <= bus.PC;
            ucause_r <= {1'b1, 27'd0, 1'b1, 1'b0, irq_id_s};
            upie_r   <= uie_r;
            uie_r    <= 1'b0;
        end else if (bus.instr_valid) begin
            if (bus.ecall) begin
                uepc_r   <= bus.PC + 32'd4;
                ucause_r <= 32'd8;
                upie_r   <= uie_r;
                uie_r    <= 1'b0;
            end else if (bus.uret) begin
                uie_r  <= upie_r;
                upie_r <= 1'b1;
            end else if (csr_hit_s && bus.CSRRSI) begin
                if (bus.zimm[0]) uie_r  <= 1'b1;
                if (bus.zimm[4]) upie_r <= 1'b1;
            end else if (csr_hit_s && bus.CSRRCI) begin
                if (bus.zimm[0]) uie_r  <= 1'b0;
                if (bus.zimm[4]) upie_r <= 1'b0;
            end
        end
    end

    // Redirect/squash decode; held quiet while reset is asserted.
    always_comb begin
        bus.pc_redirect = 1'b0;
        bus.squash      = 1'b0;
        bus.pc_target   = 32'h0000_0000;
        if (!RST_N) begin
            bus.pc_redirect = 1'b0;
        end else if (int_take_s) begin
            bus.pc_redirect = 1'b1;
            bus.squash      = 1'b1;
            bus.pc_target   = VEC_BASE + 32'd64 + {28'd0, irq_id_s, 2'b00};
        end else if (bus.instr_valid && bus.ecall) begin
            bus.pc_redirect = 1'b1;
            bus.pc_target   = VEC_BASE + 32'd32;
        end else if (bus.instr_valid && bus.uret) begin
            bus.pc_redirect = 1'b1;
            bus.pc_target   = uepc_r;
        end else begin
            bus.pc_redirect = 1'b0;
        end
    end

    assign bus.csr_rdata = csr_hit_s ? {27'd0, upie_r, 3'd0, uie_r} : 32'h0000_0000;
    assign bus.UIE       = uie_r;
    assign bus.UPIE      = upie_r;
    assign bus.UEPC      = uepc_r;
    assign bus.UCAUSE    = ucause_r;
    assign bus.pending   = pending_s;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed steps queue expected outputs,
// a negedge monitor pops and compares them.
module tb_trap_ctrl;

    logic clk;
    logic rst_n;

    trap_ctrl_if bus();

    trap_ctrl dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        redirect;
        logic [31:0] target;
        logic        squash;
        logic [31:0] rdata;
        logic        uie;
        logic        upie;
        logic [31:0] uepc;
        logic [31:0] ucause;
        logic [2:0]  pend;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_ECALL = 4'b1000;
    localparam logic [3:0] OP_URET  = 4'b0100;
    localparam logic [3:0] OP_SI    = 4'b0010;
    localparam logic [3:0] OP_CI    = 4'b0001;

    logic [134:0] got_v;
    logic [134:0] exp_v;

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            got_v = {bus.pc_redirect, (mon_e.redirect ? bus.pc_target : 32'h0), bus.squash,
                     bus.csr_rdata, bus.UIE, bus.UPIE, bus.UEPC, bus.UCAUSE, bus.pending};
            exp_v = {mon_e.redirect, (mon_e.redirect ? mon_e.target : 32'h0), mon_e.squash,
                     mon_e.rdata, mon_e.uie, mon_e.upie, mon_e.uepc, mon_e.ucause, mon_e.pend};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s: got redir=%b tgt=%h sq=%b rd=%h uie=%b upie=%b uepc=%h ucause=%h pend=%b, want redir=%b tgt=%h sq=%b rd=%h uie=%b upie=%b uepc=%h ucause=%h pend=%b",
                         mon_e.name, bus.pc_redirect, bus.pc_target, bus.squash, bus.csr_rdata,
                         bus.UIE, bus.UPIE, bus.UEPC, bus.UCAUSE, bus.pending,
                         mon_e.redirect, mon_e.target, mon_e.squash, mon_e.rdata,
                         mon_e.uie, mon_e.upie, mon_e.uepc, mon_e.ucause, mon_e.pend);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic iv,
                        input logic [31:0] pc, input logic [3:0] op,
                        input logic [11:0] addr, input logic [4:0] zimm, input logic [2:0] irq,
                        input logic rd, input logic [31:0] tgt, input logic sq,
                        input logic [31:0] rdata, input logic uie, input logic upie,
                        input logic [31:0] uepc, input logic [31:0] ucause, input logic [2:0] pend);
        exp_t e;
        rst_n           = rst;
        bus.instr_valid = iv;
        bus.PC          = pc;
        bus.ecall       = op[3];
        bus.uret        = op[2];
        bus.CSRRSI      = op[1];
        bus.CSRRCI      = op[0];
        bus.csr_addr    = addr;
        bus.zimm        = zimm;
        bus.IRQ         = irq;
        e.name = name; e.redirect = rd; e.target = tgt; e.squash = sq; e.rdata = rdata;
        e.uie = uie; e.upie = upie; e.uepc = uepc; e.ucause = ucause; e.pend = pend;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0; bus.PC = 32'h0; bus.ecall = 1'b0; bus.uret = 1'b0;
        bus.CSRRSI = 1'b0; bus.CSRRCI = 1'b0; bus.csr_addr = 12'h000; bus.zimm = 5'd0; bus.IRQ = 3'b000;
        @(posedge clk); #1;
        // name           rst   iv    PC            op        addr     zimm   irq     rd    target        sq    rdata   uie   upie  uepc          ucause        pend
        step("reset",      1'b0, 1'b1, 32'h0000_0010, OP_URET, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
        step("csrrsi_uie", 1'b1, 1'b1, 32'h0000_0010, OP_SI,   12'h000, 5'h01, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
        step("ecall",      1'b1, 1'b1, 32'h0000_0200, OP_ECALL,12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0120,1'b0, 32'h01, 1'b1, 1'b0, 32'h0,        32'h0,        3'b000);
        step("ecall_st",   1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("uret",       1'b1, 1'b1, 32'h0000_0300, OP_URET, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0204,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("uret_st",    1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("csrrci_005", 1'b1, 1'b1, 32'h0000_0304, OP_CI,   12'h005, 5'h1F, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b1, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("csrrci_uie", 1'b1, 1'b1, 32'h0000_0308, OP_CI,   12'h000, 5'h01, 3'b000, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("csrrci_upie",1'b1, 1'b1, 32'h0000_030C, OP_CI,   12'h000, 5'h1E, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("csrrsi_both",1'b1, 1'b1, 32'h0000_0310, OP_SI,   12'h000, 5'h11, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0000_0204,32'd8,        3'b000);
        step("inval_ecall",1'b1, 1'b0, 32'h0000_0400, OP_ECALL,12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("ecall_wrap", 1'b1, 1'b1, 32'hFFFF_FFFC, OP_ECALL,12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0120,1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0204,32'd8,        3'b000);
        step("wrap_st",    1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0000,32'd8,        3'b000);
        step("ecall_uie0", 1'b1, 1'b1, 32'h0000_0080, OP_ECALL,12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0120,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0000,32'd8,        3'b000);
        step("uret_upie0", 1'b1, 1'b1, 32'h0000_0090, OP_URET, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0084,1'b0, 32'h00, 1'b0, 1'b0, 32'h0000_0084,32'd8,        3'b000);
        step("uret0_st",   1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0084,32'd8,        3'b000);
        step("ecall_7c",   1'b1, 1'b1, 32'h0000_007C, OP_ECALL,12'h001, 5'h00, 3'b000, 1'b1, 32'h0000_0120,1'b0, 32'h00, 1'b0, 1'b1, 32'h0000_0084,32'd8,        3'b000);
        step("in_handler", 1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h001, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0000_0080,32'd8,        3'b000);
        step("reset_mid",  1'b0, 1'b1, 32'h0000_0100, OP_URET, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
`ifdef TRAP_CTRL_IRQ_EN
        step("irq0_pulse", 1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b001, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
        step("irq0_uie0",  1'b1, 1'b1, 32'h0000_0030, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b001);
        step("csrrsi_irq", 1'b1, 1'b1, 32'h0000_0034, OP_SI,   12'h000, 5'h01, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b001);
        step("int0_take",  1'b1, 1'b1, 32'h0000_0040, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0140,1'b1, 32'h01, 1'b1, 1'b0, 32'h0,        32'h0,        3'b001);
        step("int0_st",    1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0040,32'h8000_0010,3'b000);
        step("uret0",      1'b1, 1'b1, 32'h0000_0150, OP_URET, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0040,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0040,32'h8000_0010,3'b000);
        step("irq_all",    1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0040,32'h8000_0010,3'b000);
        step("int2_take",  1'b1, 1'b1, 32'h0000_0060, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b1, 32'h0000_0148,1'b1, 32'h11, 1'b1, 1'b1, 32'h0000_0040,32'h8000_0010,3'b111);
        step("uret2",      1'b1, 1'b1, 32'h0000_0160, OP_URET, 12'h000, 5'h00, 3'b111, 1'b1, 32'h0000_0060,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0060,32'h8000_0012,3'b011);
        step("int1_take",  1'b1, 1'b1, 32'h0000_0060, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b1, 32'h0000_0144,1'b1, 32'h11, 1'b1, 1'b1, 32'h0000_0060,32'h8000_0012,3'b011);
        step("uret1",      1'b1, 1'b1, 32'h0000_0170, OP_URET, 12'h000, 5'h00, 3'b111, 1'b1, 32'h0000_0060,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0060,32'h8000_0011,3'b001);
        step("int0_again", 1'b1, 1'b1, 32'h0000_0060, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b1, 32'h0000_0140,1'b1, 32'h11, 1'b1, 1'b1, 32'h0000_0060,32'h8000_0011,3'b001);
        step("uret_last",  1'b1, 1'b1, 32'h0000_0180, OP_URET, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0060,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0060,32'h8000_0010,3'b000);
        step("irq1_pulse", 1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b010, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0060,32'h8000_0010,3'b000);
        step("int_vs_ecall",1'b1,1'b1, 32'h0000_0240, OP_ECALL,12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0144,1'b1, 32'h11, 1'b1, 1'b1, 32'h0000_0060,32'h8000_0010,3'b010);
        step("int_ecall_st",1'b1,1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0240,32'h8000_0011,3'b000);
        step("uret_b",     1'b1, 1'b1, 32'h0000_0250, OP_URET, 12'h000, 5'h00, 3'b000, 1'b1, 32'h0000_0240,1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0240,32'h8000_0011,3'b000);
        step("irq0_pulse_b",1'b1,1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b001, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0240,32'h8000_0011,3'b000);
        step("hold_invalid",1'b1,1'b0, 32'h0000_0300, OP_ECALL,12'h000, 5'h00, 3'b001, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0240,32'h8000_0011,3'b001);
        step("irq0_low",   1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h11, 1'b1, 1'b1, 32'h0000_0240,32'h8000_0011,3'b001);
        step("set_wins",   1'b1, 1'b1, 32'h0000_0310, OP_NONE, 12'h000, 5'h00, 3'b001, 1'b1, 32'h0000_0140,1'b1, 32'h11, 1'b1, 1'b1, 32'h0000_0240,32'h8000_0011,3'b001);
        step("set_wins_st",1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b001, 1'b0, 32'h0,        1'b0, 32'h10, 1'b0, 1'b1, 32'h0000_0310,32'h8000_0010,3'b001);
        step("reset_pend", 1'b0, 1'b1, 32'h0000_0320, OP_NONE, 12'h000, 5'h00, 3'b001, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
`else
        step("csrrsi_uie2",1'b1, 1'b1, 32'h0000_0000, OP_SI,   12'h000, 5'h01, 3'b000, 1'b0, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 32'h0,        32'h0,        3'b000);
        step("irq_edge",   1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b0, 32'h0,        1'b0, 32'h01, 1'b1, 1'b0, 32'h0,        32'h0,        3'b000);
        step("irq_noint",  1'b1, 1'b1, 32'h0000_0500, OP_NONE, 12'h000, 5'h00, 3'b111, 1'b0, 32'h0,        1'b0, 32'h01, 1'b1, 1'b0, 32'h0,        32'h0,        3'b000);
        step("irq_low",    1'b1, 1'b0, 32'h0000_0000, OP_NONE, 12'h000, 5'h00, 3'b000, 1'b0, 32'h0,        1'b0, 32'h01, 1'b1, 1'b0, 32'h0,        32'h0,        3'b000);
`endif
        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d queued expectations, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
